// File: rtl/dcp_mem_dump_if.sv
// SCAN / PRINT handshakes and memory read port between a DCP dump command and the panel.
// master is the dump command side; slave is the DCP/host side.
interface dcp_mem_dump_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dout_mem;

  logic              req_rx;
  logic              type_rx;
  logic              ack_rx;
  logic              flag_rx;
  logic [31:0]       din_rx;

  logic              req_tx;
  logic              type_tx;
  logic              ack_tx;
  logic [31:0]       dout_tx;

  modport master (
    output addr, req_rx, type_rx, req_tx, type_tx, dout_tx,
    input  dout_mem, ack_rx, flag_rx, din_rx, ack_tx
  );

  modport slave (
    input  addr, req_rx, type_rx, req_tx, type_tx, dout_tx,
    output dout_mem, ack_rx, flag_rx, din_rx, ack_tx
  );
endinterface

// File: rtl/dcp_mem_dump.sv
// Memory-dump command for the debug control panel: reads an optional start address,
// then prints NUM_WORDS "AAAAAAAA:DDDDDDDD\n" lines, resuming where the last dump stopped.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | not selected; addr holds its last value
// REQ_ARG  | SCAN request for the optional hex start address
// WAIT_MEM | memory read latency down-count, then capture the word
// PR_ADDR  | PRINT the address as an 8-digit hex word
// PR_COLON | PRINT ':'
// PR_DATA  | PRINT the captured data word
// PR_NL    | PRINT newline
// NEXT     | advance address, count the line, loop or finish
// DONE     | finish high until the command is deselected
module dcp_mem_dump #(
  parameter logic [7:0]        CMD_CODE     = 8'h44,
  parameter int                NUM_WORDS    = 8,
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                ADDR_STEP    = 1,
  parameter logic [ADDR_W-1:0] DEFAULT_ADDR = '0,
  parameter int                MEM_LAT      = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     sel_mode,
  output logic           finish,
  dcp_mem_dump_if.master bus
);

  typedef enum logic [3:0] {
    IDLE,
    REQ_ARG,
    WAIT_MEM,
    PR_ADDR,
    PR_COLON,
    PR_DATA,
    PR_NL,
    NEXT,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] STEP_V    = ADDR_W'(ADDR_STEP);
  localparam logic [7:0]        LINES_INI = 8'(NUM_WORDS - 1);
  localparam logic [1:0]        LAT_INI   = 2'(MEM_LAT);

  state_t            state_q, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [ADDR_W-1:0] last_addr_q, last_addr_nxt;
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic [7:0]        lines_q, lines_nxt;
  logic [1:0]        lat_q, lat_nxt;
  logic              req_rx_q, req_rx_nxt;
  logic              req_tx_q, req_tx_nxt;
  logic              type_tx_q, type_tx_nxt;
  logic [31:0]       dout_tx_q, dout_tx_nxt;
  logic              finish_q, finish_nxt;
  logic              abort;
  logic              rx_done;
  logic              tx_done;
  logic              unused_din;

  function automatic logic is_print(input state_t s);
    return s inside {PR_ADDR, PR_COLON, PR_DATA, PR_NL};
  endfunction

  assign abort    = (state_q != IDLE) && (sel_mode != CMD_CODE);
  assign rx_done  = req_rx_q && bus.ack_rx;
  assign tx_done  = req_tx_q && bus.ack_tx;
  assign addr_inc = addr_q + STEP_V;

  // upper SCAN bits are dropped when the address register is narrower than 32 bits
  assign unused_din = ^bus.din_rx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= DEFAULT_ADDR;
      last_addr_q <= DEFAULT_ADDR;
      data_q      <= '0;
      lines_q     <= '0;
      lat_q       <= '0;
      req_rx_q    <= 1'b0;
      req_tx_q    <= 1'b0;
      type_tx_q   <= 1'b0;
      dout_tx_q   <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      addr_q      <= addr_nxt;
      last_addr_q <= last_addr_nxt;
      data_q      <= data_nxt;
      lines_q     <= lines_nxt;
      lat_q       <= lat_nxt;
      req_rx_q    <= req_rx_nxt;
      req_tx_q    <= req_tx_nxt;
      type_tx_q   <= type_tx_nxt;
      dout_tx_q   <= dout_tx_nxt;
      finish_q    <= finish_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    addr_nxt      = addr_q;
    last_addr_nxt = last_addr_q;
    data_nxt      = data_q;
    lines_nxt     = lines_q;
    lat_nxt       = lat_q;
    type_tx_nxt   = type_tx_q;
    dout_tx_nxt   = dout_tx_q;

    if (abort) begin
      // an ack coinciding with deselect is dropped; remember the first unprinted address
      state_nxt = IDLE;
      if (state_q == NEXT) begin
        addr_nxt      = addr_inc;
        last_addr_nxt = addr_inc;
      end else if (state_q != DONE) begin
        last_addr_nxt = addr_q;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sel_mode == CMD_CODE) state_nxt = REQ_ARG;
        end
        REQ_ARG: begin
          if (rx_done) begin
            addr_nxt  = bus.flag_rx ? bus.din_rx[ADDR_W-1:0] : last_addr_q;
            lines_nxt = LINES_INI;
            lat_nxt   = LAT_INI;
            state_nxt = WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (lat_q == 2'd0) begin
            data_nxt  = bus.dout_mem;
            state_nxt = PR_ADDR;
          end else begin
            lat_nxt = lat_q - 2'd1;
          end
        end
        PR_ADDR:  if (tx_done) state_nxt = PR_COLON;
        PR_COLON: if (tx_done) state_nxt = PR_DATA;
        PR_DATA:  if (tx_done) state_nxt = PR_NL;
        PR_NL:    if (tx_done) state_nxt = NEXT;
        NEXT: begin
          addr_nxt = addr_inc;
          lat_nxt  = LAT_INI;
          if (lines_q == 8'd0) begin
            last_addr_nxt = addr_inc;
            state_nxt     = DONE;
          end else begin
            lines_nxt = lines_q - 8'd1;
            state_nxt = WAIT_MEM;
          end
        end
        DONE: state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end

    case (state_nxt)
      PR_ADDR: begin
        type_tx_nxt = 1'b1;
        dout_tx_nxt = 32'(addr_q);
      end
      PR_COLON: begin
        type_tx_nxt = 1'b0;
        dout_tx_nxt = 32'h0000_003A;
      end
      PR_DATA: begin
        type_tx_nxt = 1'b1;
        dout_tx_nxt = 32'(data_q);
      end
      PR_NL: begin
        type_tx_nxt = 1'b0;
        dout_tx_nxt = 32'h0000_000A;
      end
      default: ;
    endcase
  end

  // a fresh print request rises one cycle after entering its state, giving the
  // mandatory low cycle after each ack; type/data are already stable by then
  assign req_rx_nxt = (state_nxt == REQ_ARG);
  assign req_tx_nxt = is_print(state_nxt) && (state_nxt == state_q);
  assign finish_nxt = (state_nxt == DONE);

  assign bus.addr    = addr_q;
  assign bus.req_rx  = req_rx_q;
  assign bus.type_rx = 1'b1;
  assign bus.req_tx  = req_tx_q;
  assign bus.type_tx = type_tx_q;
  assign bus.dout_tx = dout_tx_q;
  assign finish      = finish_q;

endmodule

// File: tb/tb_dcp_mem_dump.sv
// Directed bench for dcp_mem_dump: a default instance (D, combinational memory) and a
// narrow wrapping instance with two-cycle memory latency, driven from a command table.
module tb_dcp_mem_dump;

  typedef struct {
    int          dut;
    bit          flag;
    logic [31:0] din;
    logic [31:0] exp_start;
    int          abort_line;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sel0, sel1;
  logic        fin0, fin1;
  logic        ack_rx_t, flag_t, ack_tx_t;
  logic [31:0] din_t;
  logic [7:0]  a_d1, a_d2;
  int          cur;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic        req_rx_m, type_rx_m, req_tx_m, type_tx_m, fin_m;
  logic [31:0] dout_tx_m, addr_m;

  dcp_mem_dump_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  dcp_mem_dump_if #(.ADDR_W(8),  .DATA_W(32)) if1 ();

  dcp_mem_dump u_dut0 (
    .clk(clk), .rst(rst), .sel_mode(sel0), .finish(fin0), .bus(if0.master)
  );

  dcp_mem_dump #(
    .CMD_CODE(8'h49), .NUM_WORDS(3), .ADDR_W(8), .DATA_W(32), .ADDR_STEP(4), .MEM_LAT(2)
  ) u_dut1 (
    .clk(clk), .rst(rst), .sel_mode(sel1), .finish(fin1), .bus(if1.master)
  );

  always #5 clk = ~clk;

  assign if0.ack_rx   = ack_rx_t && (cur == 0);
  assign if0.flag_rx  = flag_t;
  assign if0.din_rx   = din_t;
  assign if0.ack_tx   = ack_tx_t && (cur == 0);
  assign if0.dout_mem = 32'h1000 + if0.addr;

  assign if1.ack_rx   = ack_rx_t && (cur == 1);
  assign if1.flag_rx  = flag_t;
  assign if1.din_rx   = din_t;
  assign if1.ack_tx   = ack_tx_t && (cur == 1);
  assign if1.dout_mem = 32'h1000 + {24'h0, a_d2};

  // memory for the narrow instance answers two cycles after the address
  always @(posedge clk) begin
    a_d1 <= if1.addr;
    a_d2 <= a_d1;
  end

  always_comb begin
    if (cur == 0) begin
      req_rx_m  = if0.req_rx;
      type_rx_m = if0.type_rx;
      req_tx_m  = if0.req_tx;
      type_tx_m = if0.type_tx;
      dout_tx_m = if0.dout_tx;
      addr_m    = if0.addr;
      fin_m     = fin0;
    end else begin
      req_rx_m  = if1.req_rx;
      type_rx_m = if1.type_rx;
      req_tx_m  = if1.req_tx;
      type_tx_m = if1.type_tx;
      dout_tx_m = if1.dout_tx;
      addr_m    = {24'h0, if1.addr};
      fin_m     = fin1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic set_sel(input int d, input logic [7:0] v);
    if (d == 0) sel0 = v;
    else        sel1 = v;
  endtask

  task automatic wait_req_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_tx_m) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic scan_reply(input bit flag, input logic [31:0] din, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_rx_m) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      timeout("scan req");
      return;
    end
    chk("scan type", 64'(type_rx_m), 64'd1);
    ack_rx_t = 1'b1;
    flag_t   = flag;
    din_t    = din;
    @(negedge clk);
    ack_rx_t = 1'b0;
    din_t    = 32'hBAD0_BAD0;
    chk("scan req drop", 64'(req_rx_m), 64'd0);
  endtask

  task automatic get_tx(input string name, input logic exp_type, input logic [31:0] exp_data,
                        output bit ok);
    wait_req_tx(ok);
    if (!ok) begin
      timeout(name);
      return;
    end
    chk(name, 64'({type_tx_m, dout_tx_m}), 64'({exp_type, exp_data}));
    ack_tx_t = 1'b1;
    @(negedge clk);
    ack_tx_t = 1'b0;
    chk({name, " req drop"}, 64'(req_tx_m), 64'd0);
  endtask

  task automatic run_dump(input cmd_t c);
    logic [31:0] mask, step, a, d;
    logic [7:0]  code;
    int          n;
    bit          ok, ok1, ok2, ok3, ok4, seen;
    cur  = c.dut;
    mask = (c.dut == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    step = (c.dut == 0) ? 32'd1 : 32'd4;
    n    = (c.dut == 0) ? 8 : 3;
    code = (c.dut == 0) ? 8'h44 : 8'h49;
    @(negedge clk);
    set_sel(c.dut, code);
    scan_reply(c.flag, c.din, ok);
    if (!ok) begin
      set_sel(c.dut, 8'h00);
      return;
    end
    for (int k = 0; k < n; k++) begin
      a = (c.exp_start + 32'(k) * step) & mask;
      d = 32'h1000 + a;
      get_tx("line addr", 1'b1, a, ok1);
      get_tx("colon", 1'b0, 32'h3A, ok2);
      if (k == c.abort_line) begin
        wait_req_tx(ok);
        if (!ok) timeout("abort req");
        set_sel(c.dut, 8'h00);
        ack_tx_t = 1'b1;
        @(negedge clk);
        ack_tx_t = 1'b0;
        chk("abort req drop", 64'(req_tx_m), 64'd0);
        seen = fin_m;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          seen = seen | fin_m;
        end
        chk("abort no finish", 64'(seen), 64'd0);
        return;
      end
      get_tx("data", 1'b1, d, ok3);
      get_tx("newline", 1'b0, 32'h0A, ok4);
      if (!(ok1 && ok2 && ok3 && ok4)) begin
        set_sel(c.dut, 8'h00);
        return;
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fin_m) begin
        seen = 1'b1;
        break;
      end
    end
    chk("finish set", 64'(seen), 64'd1);
    set_sel(c.dut, 8'h00);
    @(negedge clk);
    chk("finish clear", 64'(fin_m), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t tbl [6];
    bit   ok;
    tbl[0] = '{0, 1'b1, 32'h0000_0010, 32'h10, -1};
    tbl[1] = '{0, 1'b0, 32'h0000_0000, 32'h18, -1};
    tbl[2] = '{1, 1'b1, 32'h1234_56F8, 32'hF8, -1};
    tbl[3] = '{1, 1'b0, 32'h0000_0000, 32'h04, -1};
    tbl[4] = '{0, 1'b1, 32'h0000_0040, 32'h40, 2};
    tbl[5] = '{0, 1'b0, 32'h0000_0000, 32'h42, -1};

    rst      = 1'b0;
    sel0     = 8'h00;
    sel1     = 8'h00;
    ack_rx_t = 1'b0;
    ack_tx_t = 1'b0;
    flag_t   = 1'b0;
    din_t    = 32'h0;
    cur      = 0;
    #1;
    chk("rst req_rx0", 64'(if0.req_rx), 64'd0);
    chk("rst req_tx0", 64'(if0.req_tx), 64'd0);
    chk("rst finish0", 64'(fin0), 64'd0);
    chk("rst type_rx0", 64'(if0.type_rx), 64'd1);
    chk("rst type_tx0", 64'(if0.type_tx), 64'd0);
    chk("rst dout_tx0", 64'(if0.dout_tx), 64'd0);
    chk("rst addr0", 64'(if0.addr), 64'd0);
    chk("rst addr1", 64'(if1.addr), 64'd0);
    chk("rst req1", 64'({if1.req_rx, if1.req_tx, fin1}), 64'd0);

    repeat (3) @(negedge clk);
    rst = 1'b1;

    // stray acks while idle must not start anything
    ack_rx_t = 1'b1;
    ack_tx_t = 1'b1;
    flag_t   = 1'b1;
    din_t    = 32'h55;
    @(negedge clk);
    ack_rx_t = 1'b0;
    ack_tx_t = 1'b0;
    @(negedge clk);
    chk("stray ack idle", 64'({if0.req_rx, if0.req_tx, fin0}), 64'd0);
    chk("stray ack addr", 64'(if0.addr), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_dump(tbl[i]);
      repeat (2) @(negedge clk);
    end

    // asynchronous reset in the middle of a print handshake
    cur = 0;
    @(negedge clk);
    sel0 = 8'h44;
    scan_reply(1'b1, 32'h80, ok);
    wait_req_tx(ok);
    if (!ok) timeout("req before reset");
    #2 rst = 1'b0;
    #1;
    chk("async rst req_tx", 64'(req_tx_m), 64'd0);
    chk("async rst addr", 64'(addr_m), 64'd0);
    chk("async rst type/dout", 64'({type_tx_m, dout_tx_m}), 64'd0);
    @(negedge clk);
    sel0 = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    run_dump('{0, 1'b0, 32'hDEAD_BEEF, 32'h0, -1});

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
